// File: rtl/gerenciador_de_ataque_param_if.sv
// Shot-entry and status bundle for the battleship attack manager.
// Master is the coordinate-entry/display side, slave is the attack manager.
interface gerenciador_de_ataque_param_if #(
    parameter int COLS    = 5,
    parameter int ROWS    = 7,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 6
);
    localparam int MAP_W = COLS * ROWS;

    logic               enable;
    logic               confirmar;
    logic [COORD_W-1:0] coordColuna;
    logic [COORD_W-1:0] coordLinha;
    logic [MAP_W-1:0]   mapa;
    logic [MAP_W-1:0]   matriz;
    logic [MAP_W-1:0]   tiros;
    logic [CNT_W-1:0]   shots_count;
    logic [CNT_W-1:0]   hits_count;
    logic               LED_G;
    logic               LED_R;
    logic               LED_B;
    logic               fim_jogo;
    logic               vitoria;

    modport master (
        output enable, confirmar, coordColuna, coordLinha, mapa,
        input  matriz, tiros, shots_count, hits_count,
        input  LED_G, LED_R, LED_B, fim_jogo, vitoria
    );

    modport slave (
        input  enable, confirmar, coordColuna, coordLinha, mapa,
        output matriz, tiros, shots_count, hits_count,
        output LED_G, LED_R, LED_B, fim_jogo, vitoria
    );
endinterface

// File: rtl/gerenciador_de_ataque_param.sv
// Clocked attack manager: classifies confirmed shots against the ship map,
// tracks hit/shot masks and counters, and ends the game on win or shot exhaustion.
//
// state | meaning
// IDLE  | game disabled, everything cleared
// PLAY  | accepting shot events
// WIN   | all ships hit, frozen
// LOSE  | shot budget exhausted, frozen
module gerenciador_de_ataque_param #(
    parameter int COLS      = 5,
    parameter int ROWS      = 7,
    parameter int COORD_W   = 3,
    parameter int MAX_SHOTS = 15,
    parameter int CNT_W     = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    gerenciador_de_ataque_param_if.slave  bus
);
    localparam int MAP_W = COLS * ROWS;

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    state_t             state_q, state_d;
    logic               conf_q;
    logic [CNT_W-1:0]   ship_total_q, ship_total_d;
    logic [MAP_W-1:0]   matriz_q, matriz_d;
    logic [MAP_W-1:0]   tiros_q, tiros_d;
    logic [CNT_W-1:0]   shots_q, shots_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [2:0]         leds_q, leds_d;   // {G, R, B}

    logic               shot_evt;
    logic               in_range;
    logic [31:0]        cell_idx;
    logic [MAP_W-1:0]   cell_mask;
    logic               repeat_shot;
    logic               is_hit;
    logic [CNT_W-1:0]   map_popcount;

    always_comb begin
        map_popcount = '0;
        for (int i = 0; i < MAP_W; i++) begin
            map_popcount = map_popcount + CNT_W'(bus.mapa[i]);
        end
    end

    // Out-of-range coordinates yield an empty mask so they never touch state.
    always_comb begin
        shot_evt    = bus.confirmar & ~conf_q;
        in_range    = (32'(bus.coordColuna) < 32'(COLS)) && (32'(bus.coordLinha) < 32'(ROWS));
        cell_idx    = 32'(bus.coordColuna) * 32'(ROWS) + 32'(bus.coordLinha);
        cell_mask   = in_range ? (MAP_W'(1) << cell_idx) : '0;
        repeat_shot = |(tiros_q & cell_mask);
        is_hit      = |(bus.mapa & cell_mask);
    end

    always_comb begin
        state_d      = state_q;
        ship_total_d = ship_total_q;
        matriz_d     = matriz_q;
        tiros_d      = tiros_q;
        shots_d      = shots_q;
        hits_d       = hits_q;
        leds_d       = leds_q;

        if (!bus.enable) begin
            state_d      = IDLE;
            ship_total_d = '0;
            matriz_d     = '0;
            tiros_d      = '0;
            shots_d      = '0;
            hits_d       = '0;
            leds_d       = 3'b000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ship_total_d = map_popcount;
                    state_d      = PLAY;
                end
                PLAY: begin
                    if (shot_evt) begin
                        if (!in_range || repeat_shot) begin
                            leds_d = 3'b001;
                        end else begin
                            tiros_d = tiros_q | cell_mask;
                            shots_d = shots_q + CNT_W'(1);
                            if (is_hit) begin
                                matriz_d = matriz_q | cell_mask;
                                hits_d   = hits_q + CNT_W'(1);
                                leds_d   = 3'b100;
                            end else begin
                                leds_d   = 3'b010;
                            end
                        end
                        if (hits_d == ship_total_q) begin
                            state_d = WIN;
                        end else if (shots_d == CNT_W'(MAX_SHOTS)) begin
                            state_d = LOSE;
                        end
                    end else if (hits_q == ship_total_q) begin
                        // Empty map: the game is already won before any shot.
                        state_d = WIN;
                    end
                end
                WIN, LOSE: begin
                    state_d = state_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            conf_q       <= 1'b0;
            ship_total_q <= '0;
            matriz_q     <= '0;
            tiros_q      <= '0;
            shots_q      <= '0;
            hits_q       <= '0;
            leds_q       <= 3'b000;
        end else begin
            state_q      <= state_d;
            conf_q       <= bus.confirmar;
            ship_total_q <= ship_total_d;
            matriz_q     <= matriz_d;
            tiros_q      <= tiros_d;
            shots_q      <= shots_d;
            hits_q       <= hits_d;
            leds_q       <= leds_d;
        end
    end

    assign bus.matriz      = matriz_q;
    assign bus.tiros       = tiros_q;
    assign bus.shots_count = shots_q;
    assign bus.hits_count  = hits_q;
    assign bus.LED_G       = leds_q[2];
    assign bus.LED_R       = leds_q[1];
    assign bus.LED_B       = leds_q[0];
    assign bus.vitoria     = (state_q == WIN);
    assign bus.fim_jogo    = (state_q == WIN) || (state_q == LOSE);
endmodule

// File: tb/tb_gerenciador_de_ataque_param.sv
// Directed bench for the attack manager using the default 5x7 board.
module tb_gerenciador_de_ataque_param;
    localparam int COLS = 5, ROWS = 7, COORD_W = 3, MAX_SHOTS = 15, CNT_W = 6;
    localparam int MAP_W = COLS * ROWS;
    localparam logic [MAP_W-1:0] SHIP_MAP = 35'h7_0000_1071;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    gerenciador_de_ataque_param_if #(.COLS(COLS), .ROWS(ROWS), .COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

    gerenciador_de_ataque_param #(
        .COLS(COLS), .ROWS(ROWS), .COORD_W(COORD_W), .MAX_SHOTS(MAX_SHOTS), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [4:0] st = {bus.LED_G, bus.LED_R, bus.LED_B, bus.fim_jogo, bus.vitoria};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shoot(input int c, input int r);
        bus.coordColuna = COORD_W'(c);
        bus.coordLinha  = COORD_W'(r);
        bus.confirmar   = 1'b1;
        tick();
        bus.confirmar   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.confirmar = 1'b0;
        bus.coordColuna = '0;
        bus.coordLinha = '0;
        bus.mapa = SHIP_MAP;
        tick();
        tick();
        n_vec++;
        if ({bus.matriz, bus.tiros} !== '0) begin
            n_err++; $display("FAIL reset_masks got %h/%h want 0/0", bus.matriz, bus.tiros);
        end
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== '0) begin
            n_err++; $display("FAIL reset_status got %0d/%0d/%b want 0/0/00000", bus.shots_count, bus.hits_count, st);
        end
        reset = 1'b0;
        tick();
        tick();
        n_vec++;
        if (st !== 5'b00000) begin
            n_err++; $display("FAIL play_entry got %b want 00000", st);
        end
    endtask

    task automatic test_hit_and_hold();
        bus.coordColuna = 3'd0;
        bus.coordLinha  = 3'd0;
        bus.confirmar   = 1'b1;
        tick();
        n_vec++;
        if ({bus.matriz, bus.tiros} !== {35'h1, 35'h1}) begin
            n_err++; $display("FAIL hit_masks got %h/%h want 1/1", bus.matriz, bus.tiros);
        end
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== {6'd1, 6'd1, 5'b10000}) begin
            n_err++; $display("FAIL hit_status got %0d/%0d/%b want 1/1/10000", bus.shots_count, bus.hits_count, st);
        end
        repeat (5) tick();
        n_vec++;
        if ({bus.tiros, bus.shots_count, bus.hits_count, st} !== {35'h1, 6'd1, 6'd1, 5'b10000}) begin
            n_err++; $display("FAIL hold_no_repeat got %h/%0d/%0d/%b want 1/1/1/10000", bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        bus.confirmar = 1'b0;
        tick();
    endtask

    task automatic test_miss();
        shoot(0, 1);
        n_vec++;
        if ({bus.matriz, bus.tiros} !== {35'h1, 35'h3}) begin
            n_err++; $display("FAIL miss_masks got %h/%h want 1/3", bus.matriz, bus.tiros);
        end
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== {6'd2, 6'd1, 5'b01000}) begin
            n_err++; $display("FAIL miss_status got %0d/%0d/%b want 2/1/01000", bus.shots_count, bus.hits_count, st);
        end
    endtask

    task automatic test_reject();
        shoot(0, 0);
        n_vec++;
        if ({bus.tiros, bus.shots_count, bus.hits_count, st} !== {35'h3, 6'd2, 6'd1, 5'b00100}) begin
            n_err++; $display("FAIL repeat got %h/%0d/%0d/%b want 3/2/1/00100", bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        shoot(1, 0);
        shoot(5, 0);
        n_vec++;
        if ({bus.tiros, bus.shots_count, bus.hits_count, st} !== {35'h83, 6'd3, 6'd1, 5'b00100}) begin
            n_err++; $display("FAIL col_range got %h/%0d/%0d/%b want 83/3/1/00100", bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        shoot(0, 7);
        n_vec++;
        if ({bus.matriz, bus.tiros, bus.shots_count} !== {35'h1, 35'h83, 6'd3}) begin
            n_err++; $display("FAIL row_range got %h/%h/%0d want 1/83/3", bus.matriz, bus.tiros, bus.shots_count);
        end
    endtask

    task automatic test_win();
        shoot(0, 4); shoot(0, 5); shoot(0, 6);
        shoot(1, 5); shoot(4, 4); shoot(4, 5);
        n_vec++;
        if ({bus.hits_count, st} !== {6'd7, 5'b10000}) begin
            n_err++; $display("FAIL before_win got %0d/%b want 7/10000", bus.hits_count, st);
        end
        shoot(4, 6);
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== {6'd10, 6'd8, 5'b10011}) begin
            n_err++; $display("FAIL win got %0d/%0d/%b want 10/8/10011", bus.shots_count, bus.hits_count, st);
        end
        n_vec++;
        if ({bus.matriz, bus.tiros} !== {SHIP_MAP, SHIP_MAP | 35'h83}) begin
            n_err++; $display("FAIL win_masks got %h/%h want %h/%h", bus.matriz, bus.tiros, SHIP_MAP, SHIP_MAP | 35'h83);
        end
        shoot(2, 2);
        n_vec++;
        if ({bus.tiros, bus.shots_count, st} !== {SHIP_MAP | 35'h83, 6'd10, 5'b10011}) begin
            n_err++; $display("FAIL win_frozen got %h/%0d/%b want %h/10/10011", bus.tiros, bus.shots_count, st, SHIP_MAP | 35'h83);
        end
    endtask

    task automatic test_lose();
        bus.enable = 1'b0;
        tick();
        n_vec++;
        if ({bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st} !== '0) begin
            n_err++; $display("FAIL disable_clear got %h/%h/%0d/%0d/%b want all 0", bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        bus.enable = 1'b1;
        tick();
        for (int c = 2; c <= 3; c++)
            for (int r = 0; r < ROWS; r++)
                shoot(c, r);
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== {6'd14, 6'd0, 5'b01000}) begin
            n_err++; $display("FAIL before_lose got %0d/%0d/%b want 14/0/01000", bus.shots_count, bus.hits_count, st);
        end
        shoot(1, 0);
        n_vec++;
        if ({bus.shots_count, bus.tiros, st} !== {6'd15, 35'h0FFFC080, 5'b01010}) begin
            n_err++; $display("FAIL lose got %0d/%h/%b want 15/0fffc080/01010", bus.shots_count, bus.tiros, st);
        end
        shoot(0, 0);
        n_vec++;
        if ({bus.shots_count, bus.hits_count, st} !== {6'd15, 6'd0, 5'b01010}) begin
            n_err++; $display("FAIL lose_frozen got %0d/%0d/%b want 15/0/01010", bus.shots_count, bus.hits_count, st);
        end
    endtask

    task automatic test_enable_drop();
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick();
        shoot(0, 0);
        bus.coordColuna = 3'd0;
        bus.coordLinha  = 3'd4;
        bus.confirmar   = 1'b1;
        bus.enable      = 1'b0;
        tick();
        n_vec++;
        if ({bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st} !== '0) begin
            n_err++; $display("FAIL enable_priority got %h/%h/%0d/%0d/%b want all 0", bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        bus.confirmar = 1'b0;
        tick();
    endtask

    task automatic test_reset_priority();
        bus.enable = 1'b1;
        tick();
        shoot(0, 0);
        n_vec++;
        if ({bus.hits_count, st} !== {6'd1, 5'b10000}) begin
            n_err++; $display("FAIL pre_reset_hit got %0d/%b want 1/10000", bus.hits_count, st);
        end
        bus.coordLinha = 3'd4;
        bus.confirmar  = 1'b1;
        reset          = 1'b1;
        tick();
        n_vec++;
        if ({bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st} !== '0) begin
            n_err++; $display("FAIL reset_priority got %h/%h/%0d/%0d/%b want all 0", bus.matriz, bus.tiros, bus.shots_count, bus.hits_count, st);
        end
        reset = 1'b0;
        bus.confirmar = 1'b0;
        tick();
    endtask

    task automatic test_zero_ships();
        bus.mapa = '0;
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick();
        n_vec++;
        if (st !== 5'b00000) begin
            n_err++; $display("FAIL zero_ship_play got %b want 00000", st);
        end
        tick();
        n_vec++;
        if ({bus.shots_count, st} !== {6'd0, 5'b00011}) begin
            n_err++; $display("FAIL zero_ship_win got %0d/%b want 0/00011", bus.shots_count, st);
        end
        shoot(0, 0);
        n_vec++;
        if ({bus.tiros, bus.shots_count, st} !== {35'h0, 6'd0, 5'b00011}) begin
            n_err++; $display("FAIL zero_ship_frozen got %h/%0d/%b want 0/0/00011", bus.tiros, bus.shots_count, st);
        end
    endtask

    initial begin
        test_reset();
        test_hit_and_hold();
        test_miss();
        test_reject();
        test_win();
        test_lose();
        test_enable_drop();
        test_reset_priority();
        test_zero_ships();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
